// File: rtl/hotspot_pos_ctrl.sv
// Hotspot overlay position sequencer. It averages blocks of localisation samples and clamps the result to the panel.
// The new position is committed only at frame start, and the hotspot is blanked when samples stop arriving.
module hotspot_pos_ctrl #(
    parameter int AVG_LOG2       = 2,
    parameter int H_RES          = 480,
    parameter int V_RES          = 272,
    parameter int DEADBAND       = 2,
    parameter int TIMEOUT_FRAMES = 30
) (
    input  logic        clk_pix,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_x,
    input  logic [31:0] in_y,
    input  logic        frame_vs,
    output logic        pos_ena,
    output logic [31:0] pos_x,
    output logic [31:0] pos_y,
    output logic        hotspot_on,
    output logic        busy
);

    typedef enum logic [1:0] {ACCUM, WAIT_FRAME, COMMIT} state_t;

    localparam logic [AVG_LOG2:0]  CNT_LAST = (AVG_LOG2 + 1)'((1 << AVG_LOG2) - 1);
    localparam logic signed [39:0] X_MAX    = 40'(H_RES);
    localparam logic signed [39:0] Y_MAX    = 40'(V_RES);
    localparam logic signed [32:0] DB_LIM   = 33'(DEADBAND);
    localparam logic [7:0]         T_MAX    = 8'(TIMEOUT_FRAMES);

    state_t state, state_nx;

    logic                  rdy_en;
    logic                  vs_q, vs_qq, fs;
    logic signed [39:0]    sum_x, sum_y, sum_x_nx, sum_y_nx, avg_x, avg_y;
    logic [AVG_LOG2:0]     cnt;
    logic [31:0]           ax_q, ay_q, ax_cl, ay_cl;
    logic [7:0]            frame_cnt, frame_inc;
    logic                  accept, block_done, do_update;
    logic signed [32:0]    dx, dy, adx, ady;

    always_comb begin
        in_ready   = rdy_en && (state == ACCUM);
        busy       = (state != ACCUM);
        fs         = vs_q && !vs_qq;
        accept     = in_ready && in_valid;
        block_done = accept && (cnt == CNT_LAST);

        sum_x_nx = sum_x + $signed({{8{in_x[31]}}, in_x});
        sum_y_nx = sum_y + $signed({{8{in_y[31]}}, in_y});
        avg_x    = sum_x_nx >>> AVG_LOG2;
        avg_y    = sum_y_nx >>> AVG_LOG2;

        ax_cl = (avg_x < 0) ? '0 : (avg_x > X_MAX) ? X_MAX[31:0] : avg_x[31:0];
        ay_cl = (avg_y < 0) ? '0 : (avg_y > Y_MAX) ? Y_MAX[31:0] : avg_y[31:0];

        // Both operands are already clamped non-negative, so a zero-extended difference is exact.
        dx  = $signed({1'b0, ax_q}) - $signed({1'b0, pos_x});
        dy  = $signed({1'b0, ay_q}) - $signed({1'b0, pos_y});
        adx = dx[32] ? -dx : dx;
        ady = dy[32] ? -dy : dy;
        do_update = !hotspot_on || (adx > DB_LIM) || (ady > DB_LIM);

        frame_inc = (frame_cnt == T_MAX) ? T_MAX : frame_cnt + 8'd1;

        state_nx = state;
        case (state)
            ACCUM:      if (block_done) state_nx = WAIT_FRAME;
            WAIT_FRAME: if (fs)         state_nx = COMMIT;
            COMMIT:                     state_nx = ACCUM;
            default:                    state_nx = ACCUM;
        endcase
    end

    always_ff @(posedge clk_pix or posedge rst) begin
        if (rst) begin
            state      <= ACCUM;
            rdy_en     <= 1'b0;
            vs_q       <= 1'b0;
            vs_qq      <= 1'b0;
            sum_x      <= '0;
            sum_y      <= '0;
            cnt        <= '0;
            ax_q       <= '0;
            ay_q       <= '0;
            frame_cnt  <= '0;
            pos_ena    <= 1'b0;
            pos_x      <= '0;
            pos_y      <= '0;
            hotspot_on <= 1'b0;
        end else begin
            state   <= state_nx;
            rdy_en  <= 1'b1;
            vs_q    <= frame_vs;
            vs_qq   <= vs_q;
            pos_ena <= 1'b0;

            // A frame start that launches a commit must not blank the hotspot it is about to refresh.
            if (fs && state != COMMIT) begin
                frame_cnt <= frame_inc;
                if (frame_inc == T_MAX && state != WAIT_FRAME)
                    hotspot_on <= 1'b0;
            end

            case (state)
                ACCUM: begin
                    if (block_done) begin
                        sum_x <= '0;
                        sum_y <= '0;
                        cnt   <= '0;
                        ax_q  <= ax_cl;
                        ay_q  <= ay_cl;
                    end else if (accept) begin
                        sum_x <= sum_x_nx;
                        sum_y <= sum_y_nx;
                        cnt   <= cnt + 1'b1;
                    end
                end
                COMMIT: begin
                    if (do_update) begin
                        pos_x   <= ax_q;
                        pos_y   <= ay_q;
                        pos_ena <= 1'b1;
                    end
                    hotspot_on <= 1'b1;
                    frame_cnt  <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hotspot_pos_ctrl.sv
// Directed and randomized bench for hotspot_pos_ctrl.
// It checks the DUT against a sample-queue reference model that applies the averaging, clamp, deadband and timeout rules directly.
module tb_hotspot_pos_ctrl;

    localparam int N  = 4;
    localparam int HR = 480;
    localparam int VR = 272;
    localparam int DB = 2;
    localparam int TO = 30;

    logic        clk_pix = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_x = '0;
    logic [31:0] in_y = '0;
    logic        frame_vs = 1'b0;
    logic        pos_ena;
    logic [31:0] pos_x, pos_y;
    logic        hotspot_on;
    logic        busy;

    int total = 0;
    int bad   = 0;

    longint q_x[$];
    longint q_y[$];
    bit     m_pending = 0;
    bit     m_hot     = 0;
    int     m_ax = 0, m_ay = 0, m_pos_x = 0, m_pos_y = 0, m_fcnt = 0;

    hotspot_pos_ctrl #(
        .AVG_LOG2(2),
        .H_RES(HR),
        .V_RES(VR),
        .DEADBAND(DB),
        .TIMEOUT_FRAMES(TO)
    ) dut (
        .clk_pix(clk_pix),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_x(in_x),
        .in_y(in_y),
        .frame_vs(frame_vs),
        .pos_ena(pos_ena),
        .pos_x(pos_x),
        .pos_y(pos_y),
        .hotspot_on(hotspot_on),
        .busy(busy)
    );

    always #5 clk_pix = ~clk_pix;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    function automatic int floor_avg(longint s);
        longint q;
        q = s / N;
        if ((s % N) != 0 && s < 0) q = q - 1;
        return int'(q);
    endfunction

    function automatic int clamp(int v, int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic int iabs(int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic model_push(int x, int y);
        longint sx, sy;
        q_x.push_back(x);
        q_y.push_back(y);
        if (q_x.size() == N) begin
            sx = 0;
            sy = 0;
            foreach (q_x[i]) begin
                sx += q_x[i];
                sy += q_y[i];
            end
            m_ax = clamp(floor_avg(sx), HR);
            m_ay = clamp(floor_avg(sy), VR);
            m_pending = 1;
            q_x.delete();
            q_y.delete();
        end
    endtask

    task automatic model_reset();
        q_x.delete();
        q_y.delete();
        m_pending = 0;
        m_hot = 0;
        m_pos_x = 0;
        m_pos_y = 0;
        m_fcnt = 0;
    endtask

    // Starts and ends on a falling edge; drops in_valid once the sample is taken.
    task automatic send(int x, int y);
        bit acc = 0;
        in_valid = 1'b1;
        in_x = x;
        in_y = y;
        for (int k = 0; k < 20 && !acc; k++) begin
            acc = in_ready;
            @(posedge clk_pix);
            @(negedge clk_pix);
        end
        in_valid = 1'b0;
        check("accept", 32'(acc), 32'd1);
        if (acc) model_push(x, y);
    endtask

    task automatic send_block(int x, int y);
        for (int i = 0; i < N; i++) send(x, y);
    endtask

    // One frame_vs pulse. The commit (if any) is expected on the third rising edge after the pulse starts.
    task automatic frame();
        bit pend;
        bit upd;
        pend = m_pending;
        upd  = 0;
        if (pend) begin
            upd = !m_hot || iabs(m_ax - m_pos_x) > DB || iabs(m_ay - m_pos_y) > DB;
            if (upd) begin
                m_pos_x = m_ax;
                m_pos_y = m_ay;
            end
            m_hot = 1;
            m_fcnt = 0;
            m_pending = 0;
        end else begin
            if (m_fcnt < TO) m_fcnt++;
            if (m_fcnt == TO) m_hot = 0;
        end
        frame_vs = 1'b1;
        @(negedge clk_pix);
        frame_vs = 1'b0;
        check("ena_c1", 32'(pos_ena), 32'd0);
        check("busy_c1", 32'(busy), 32'(pend));
        check("rdy_c1", 32'(in_ready), 32'(!pend));
        @(negedge clk_pix);
        check("ena_c2", 32'(pos_ena), 32'd0);
        check("busy_c2", 32'(busy), 32'(pend));
        check("rdy_c2", 32'(in_ready), 32'(!pend));
        @(negedge clk_pix);
        check("ena_c3", 32'(pos_ena), 32'(upd));
        check("pos_x", pos_x, 32'(m_pos_x));
        check("pos_y", pos_y, 32'(m_pos_y));
        check("hot", 32'(hotspot_on), 32'(m_hot));
        check("rdy_c3", 32'(in_ready), 32'd1);
        check("busy_c3", 32'(busy), 32'd0);
        @(negedge clk_pix);
        check("ena_c4", 32'(pos_ena), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_rdy", 32'(in_ready), 32'd0);
        check("rst_ena", 32'(pos_ena), 32'd0);
        check("rst_px", pos_x, 32'd0);
        check("rst_py", pos_y, 32'd0);
        check("rst_hot", 32'(hotspot_on), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        model_reset();
        @(negedge clk_pix);
        rst = 1'b0;
        check("rdy_after_rel", 32'(in_ready), 32'd0);
        @(negedge clk_pix);
        check("rdy_first_edge", 32'(in_ready), 32'd1);
    endtask

    initial begin
        int bx, by;
        @(negedge clk_pix);
        do_reset();

        // T1: plain average, first commit
        send(100, 50); send(104, 50); send(100, 54); send(104, 54);
        check("t1_busy", 32'(busy), 32'd1);
        frame();

        // T3: within deadband, held
        send_block(103, 53);
        frame();

        // T4: held sample during WAIT_FRAME becomes first of the next block
        send_block(200, 100);
        in_valid = 1'b1;
        in_x = 32'd7;
        in_y = 32'd7;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_pix);
            check("t4_hold_rdy", 32'(in_ready), 32'd0);
        end
        frame();
        in_valid = 1'b0;
        model_push(7, 7);
        send(7, 7); send(7, 7); send(7, 7);
        frame();

        // T2: clamping at both ends of x
        send_block(-20, 10);
        frame();
        send_block(600, 10);
        frame();

        // T5: timeout, then forced commit inside the deadband
        for (int i = 0; i < TO; i++) frame();
        send_block(HR - 1, 10);
        frame();

        // Randomized blocks, some near the current position, with idle frames between
        for (int r = 0; r < 12; r++) begin
            int idle;
            idle = $urandom_range(0, 2);
            for (int i = 0; i < idle; i++) frame();
            if ($urandom_range(0, 2) == 0) begin
                bx = m_pos_x;
                by = m_pos_y;
            end else begin
                bx = int'($urandom_range(0, 800)) - 100;
                by = int'($urandom_range(0, 500)) - 100;
            end
            for (int i = 0; i < N; i++)
                send(bx + int'($urandom_range(0, 6)) - 3, by + int'($urandom_range(0, 6)) - 3);
            frame();
        end

        // T6: reset discards partial sums
        send(400, 200); send(400, 200);
        do_reset();
        send_block(10, 10);
        frame();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
